seg_fifo_scan: RTL and testbench

- Display back-end of the 7-segment comparison path: pops 16-bit words (four hex nibbles) from the upstream FIFO and time-multiplexes them onto a 4-digit common-anode display.
- Sits directly downstream of the FIFO whose fill level is exported as usedw.
- Each word is held on screen for a programmable number of full scan frames before the next word is fetched.

---
 rtl/seg_fifo_scan.sv | 201 ++++++++++++++++++++
 tb/tb_seg_fifo_scan.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_fifo_scan.sv
// seg_fifo_scan: pops 16-bit words from the upstream FIFO and time-multiplexes
// their four hex nibbles onto a 4-digit common-anode 7-segment display.
// Each word stays on screen for HOLD_FRAMES full scan frames; if the FIFO is
// still empty at that point the word keeps scanning until a word arrives.
module seg_fifo_scan #(
  parameter int SCAN_DIV    = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [6:0]  ss,
  output logic [4:1]  dig,
  output logic [7:0]  words
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(HOLD_FRAMES - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;
  localparam logic [3:0]    DIG_OFF   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_LATCH = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One-hot active-low digit enable; index 0 drives dig[1].
  function automatic logic [3:0] digit_sel(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = 4'b1110;
      2'd1:    sel = 4'b1101;
      2'd2:    sel = 4'b1011;
      2'd3:    sel = 4'b0111;
      default: sel = DIG_OFF;
    endcase
    return sel;
  endfunction

  // Nibble of the held word shown on digit index idx.
  function automatic logic [3:0] nibble_of(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = word[3:0];
      2'd1:    nib = word[7:4];
      2'd2:    nib = word[11:8];
      2'd3:    nib = word[15:12];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

  state_t          state_r,  state_nxt_s;
  logic [DW-1:0]   div_r,    div_nxt_s;
  logic [1:0]      idx_r,    idx_nxt_s;
  logic [FW-1:0]   frame_r,  frame_nxt_s;
  logic [15:0]     word_r,   word_nxt_s;
  logic [6:0]      ss_r,     ss_nxt_s;
  logic [3:0]      dig_r,    dig_nxt_s;
  logic [7:0]      words_r,  words_nxt_s;
  logic            rdreq_r,  rdreq_nxt_s;
  logic [1:0]      idx_inc_s;
  logic            hold_done_s;

  assign idx_inc_s   = idx_r + 2'd1;
  // The frame counter saturates at HOLD_LAST, so equality means "enough frames".
  assign hold_done_s = (frame_r == HOLD_LAST);

  // Next state, scan counters and the display image for the coming cycle.
  always_comb begin
    state_nxt_s = state_r;
    div_nxt_s   = div_r;
    idx_nxt_s   = idx_r;
    frame_nxt_s = frame_r;
    word_nxt_s  = word_r;
    ss_nxt_s    = ss_r;
    dig_nxt_s   = dig_r;
    words_nxt_s = words_r;
    case (state_r)
      ST_IDLE: begin
        ss_nxt_s  = SEG_BLANK;
        dig_nxt_s = DIG_OFF;
        if (EN && !fifo_empty) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        // The pop is committed once the strobe is out, so EN is ignored here.
        state_nxt_s = ST_LATCH;
        words_nxt_s = words_r + 8'd1;
      end
      ST_LATCH: begin
        if (EN) begin
          state_nxt_s = ST_SHOW;
          word_nxt_s  = fifo_q;
          div_nxt_s   = {DW{1'b0}};
          idx_nxt_s   = 2'd0;
          frame_nxt_s = {FW{1'b0}};
          // Load the display now so the first SHOW cycle already shows dig[1].
          ss_nxt_s    = hex_to_seg(fifo_q[3:0]);
          dig_nxt_s   = digit_sel(2'd0);
        end else begin
          state_nxt_s = ST_LATCH;
        end
      end
      ST_SHOW: begin
        if (!EN) begin
          state_nxt_s = ST_SHOW;
        end else if (div_r != DIV_LAST) begin
          div_nxt_s = div_r + DW'(1);
        end else if (idx_r != 2'd3) begin
          div_nxt_s = {DW{1'b0}};
          idx_nxt_s = idx_inc_s;
          ss_nxt_s  = hex_to_seg(nibble_of(word_r, idx_inc_s));
          dig_nxt_s = digit_sel(idx_inc_s);
        end else if (hold_done_s && !fifo_empty) begin
          // Frame end with a word waiting: dig[4] stays lit through REQ/LATCH.
          div_nxt_s   = {DW{1'b0}};
          state_nxt_s = ST_REQ;
        end else begin
          div_nxt_s   = {DW{1'b0}};
          idx_nxt_s   = 2'd0;
          frame_nxt_s = hold_done_s ? HOLD_LAST : (frame_r + FW'(1));
          ss_nxt_s    = hex_to_seg(word_r[3:0]);
          dig_nxt_s   = digit_sel(2'd0);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ss_nxt_s    = SEG_BLANK;
        dig_nxt_s   = DIG_OFF;
      end
    endcase
    rdreq_nxt_s = (state_nxt_s == ST_REQ);
  end

  // State, scan counters and registered display/FIFO outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
      div_r   <= {DW{1'b0}};
      idx_r   <= 2'd0;
      frame_r <= {FW{1'b0}};
      word_r  <= 16'h0000;
      ss_r    <= SEG_BLANK;
      dig_r   <= DIG_OFF;
      words_r <= 8'd0;
      rdreq_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      div_r   <= div_nxt_s;
      idx_r   <= idx_nxt_s;
      frame_r <= frame_nxt_s;
      word_r  <= word_nxt_s;
      ss_r    <= ss_nxt_s;
      dig_r   <= dig_nxt_s;
      words_r <= words_nxt_s;
      rdreq_r <= rdreq_nxt_s;
    end
  end

  assign fifo_rdreq = rdreq_r;
  assign ss         = ss_r;
  assign dig        = dig_r;
  assign words      = words_r;

endmodule

// File: tb/tb_seg_fifo_scan.sv
// Self-checking bench for seg_fifo_scan (SCAN_DIV=2, HOLD_FRAMES=1) with an
// emulated legacy-timing FIFO and an elapsed-time reference model.
module tb_seg_fifo_scan;

  localparam int SD    = 2;
  localparam int HF    = 1;
  localparam int FRAME = 4 * SD;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [15:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [6:0]  ss;
  logic [4:1]  dig;
  logic [7:0]  words;

  seg_fifo_scan #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq), .ss(ss), .dig(dig), .words(words)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // Emulated FIFO: data appears on fifo_q the cycle after the rdreq cycle.
  logic [15:0] fq[$];
  logic [15:0] pend_word;
  bit          rd_pend;

  // Reference model: display derived from elapsed enabled SHOW cycles.
  typedef enum int {M_IDLE, M_REQ, M_LATCH, M_SHOW} mmode_t;
  mmode_t      m_mode;
  int          m_t;
  logic [15:0] m_word;
  logic        m_rdreq;
  logic [3:0]  m_dig;
  logic [6:0]  m_ss;
  logic [7:0]  m_words;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] sw_dig [8] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
  logic [6:0] sw_ss  [8] = '{7'h0E, 7'h0E, 7'h24, 7'h24, 7'h08, 7'h08, 7'h79, 7'h79};
  logic [6:0] bb_ss  [8] = '{7'h30, 7'h24, 7'h79, 7'h40, 7'h78, 7'h02, 7'h12, 7'h19};

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_t     = 0;
    m_word  = 16'h0000;
    m_rdreq = 1'b0;
    m_dig   = 4'hF;
    m_ss    = 7'h7F;
    m_words = 8'd0;
  endtask

  task automatic model_step(input bit en, input bit empty, input logic [15:0] q, input bit rst_ok);
    int          digit;
    logic [3:0]  one;
    logic [15:0] sh;
    if (!rst_ok) begin
      model_reset();
    end else begin
      case (m_mode)
        M_IDLE:  if (en && !empty) m_mode = M_REQ;
        M_REQ:   begin m_mode = M_LATCH; m_words = m_words + 8'd1; end
        M_LATCH: if (en) begin m_word = q; m_t = 0; m_mode = M_SHOW; end
        M_SHOW:  if (en) begin
                   if (((m_t + 1) % FRAME == 0) && ((m_t + 1) / FRAME >= HF) && !empty)
                     m_mode = M_REQ;
                   else
                     m_t = m_t + 1;
                 end
        default: m_mode = M_IDLE;
      endcase
      m_rdreq = (m_mode == M_REQ);
      if (m_mode == M_SHOW) begin
        digit = (m_t / SD) % 4;
        one   = 4'b0001;
        m_dig = ~(one << digit);
        sh    = m_word >> (4 * digit);
        m_ss  = seg_tab[sh[3:0]];
      end
    end
  endtask

  // One clock: sample inputs before the edge, step model, then emulate FIFO.
  task automatic tick();
    bit          p_en, p_empty, p_rst;
    logic [15:0] p_q;
    @(negedge CLK);
    p_en = EN; p_empty = fifo_empty; p_rst = RST; p_q = fifo_q;
    @(posedge CLK);
    #1;
    cyc++;
    model_step(p_en, p_empty, p_q, p_rst);
    if (rd_pend) fifo_q = pend_word;
    else         fifo_q = 16'($urandom);
    rd_pend = 1'b0;
    if (fifo_rdreq === 1'b1) begin
      rd_pend = 1'b1;
      if (fq.size() > 0) pend_word = fq.pop_front();
      else               pend_word = 16'hDEAD;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    RST = 1'b0; EN = 1'b1; rd_pend = 1'b0;
    fq.delete();
    push(16'h1A2F);
    model_reset();
    repeat (3) tick();
    nvec++; if (ss !== 7'h7F) begin nfail++; $display("FAIL reset_ss got=%h want=7f", ss); end
    nvec++; if (dig !== 4'hF) begin nfail++; $display("FAIL reset_dig got=%h want=f", dig); end
    nvec++; if (fifo_rdreq !== 1'b0) begin nfail++; $display("FAIL reset_rdreq got=%b want=0", fifo_rdreq); end
    nvec++; if (words !== 8'd0) begin nfail++; $display("FAIL reset_words got=%0d want=0", words); end
    RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fifo_rdreq === 1'b1) pulses++;
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL reset_release cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
    nvec++; if (pulses != 1) begin nfail++; $display("FAIL reset_rdreq_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_single_word();
    logic [3:0] prev;
    bit         found;
    int         pulses;
    prev  = dig;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dig === 4'hE && prev !== 4'hE) found = 1'b1;
      else prev = dig;
    end
    nvec++; if (!found) begin nfail++; $display("FAIL single_word_start got=timeout want=dig e"); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      nvec++;
      if (dig !== sw_dig[k] || ss !== sw_ss[k]) begin
        nfail++;
        $display("FAIL single_word_seq step=%0d got dig=%h ss=%h want dig=%h ss=%h", k, dig, ss, sw_dig[k], sw_ss[k]);
      end
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (fifo_rdreq === 1'b1) pulses++;
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL single_word cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
    nvec++; if (pulses != 0) begin nfail++; $display("FAIL single_word_extra_rdreq got=%0d want=0", pulses); end
    nvec++; if (words !== 8'd1) begin nfail++; $display("FAIL single_word_words got=%0d want=1", words); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ss_log [40];
    int         pops [$];
    RST = 1'b0;
    fq.delete();
    rd_pend = 1'b0;
    model_reset();
    push(16'h0123);
    push(16'h4567);
    repeat (2) tick();
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      ss_log[i] = ss;
      if (fifo_rdreq === 1'b1) pops.push_back(i);
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL back_to_back cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
    nvec++;
    if (pops.size() != 2) begin
      nfail++; $display("FAIL b2b_pop_count got=%0d want=2", pops.size());
    end else if (pops[1] - pops[0] != 10) begin
      nfail++; $display("FAIL b2b_spacing got=%0d want=10", pops[1] - pops[0]);
    end else begin
      for (int d = 0; d < 8; d++) begin
        int idx;
        idx = pops[0] + 2 + 2 * d + ((d >= 4) ? 2 : 0);
        nvec++;
        if (ss_log[idx] !== bb_ss[d]) begin
          nfail++; $display("FAIL b2b_ss digit=%0d got=%h want=%h", d, ss_log[idx], bb_ss[d]);
        end
      end
    end
    nvec++; if (words !== 8'd2) begin nfail++; $display("FAIL b2b_words got=%0d want=2", words); end
  endtask

  task automatic test_enable_freeze();
    logic [3:0] prev, snap_dig;
    logic [6:0] snap_ss;
    prev = dig;
    for (int i = 0; i < 2 * SD + 2; i++) begin
      tick();
      if (dig !== prev) break;
    end
    snap_dig = dig;
    snap_ss  = ss;
    EN = 1'b0;
    push(16'($urandom));
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++;
      if (dig !== snap_dig || ss !== snap_ss || fifo_rdreq !== 1'b0) begin
        nfail++;
        $display("FAIL en_freeze cyc=%0d got rd=%b dig=%h ss=%h want rd=0 dig=%h ss=%h",
                 cyc, fifo_rdreq, dig, ss, snap_dig, snap_ss);
      end
    end
    EN = 1'b1;
    tick();
    nvec++;
    if (dig !== snap_dig || ss !== snap_ss) begin
      nfail++; $display("FAIL en_resume got dig=%h ss=%h want dig=%h ss=%h", dig, ss, snap_dig, snap_ss);
    end
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL en_after cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
  endtask

  task automatic test_midframe_fill();
    bit seen;
    int waited;
    repeat ($urandom_range(0, FRAME - 1)) tick();
    push(16'($urandom));
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 2 * FRAME + 2 && !seen; i++) begin
      tick();
      waited++;
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL midframe cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
      if (fifo_rdreq === 1'b1) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nfail++; $display("FAIL midframe_rdreq got=timeout want=pulse");
    end else if (dig !== 4'h7 || waited > FRAME) begin
      nfail++; $display("FAIL midframe_at_frame_end got dig=%h waited=%0d want dig=7 waited<=%0d", dig, waited, FRAME);
    end
  endtask

  task automatic test_reset_latch();
    bit seen;
    int pulses;
    repeat (2 * FRAME) tick();
    push(16'hBEEF);
    seen = 1'b0;
    for (int i = 0; i < FRAME + 3 && !seen; i++) begin
      tick();
      if (fifo_rdreq === 1'b1) seen = 1'b1;
    end
    nvec++; if (!seen) begin nfail++; $display("FAIL rst_latch_req got=timeout want=pulse"); end
    tick();
    RST = 1'b0;
    #1;
    model_reset();
    nvec++;
    if (ss !== 7'h7F || dig !== 4'hF || fifo_rdreq !== 1'b0 || words !== 8'd0) begin
      nfail++;
      $display("FAIL rst_latch_blank got rd=%b dig=%h ss=%h words=%0d want rd=0 dig=f ss=7f words=0",
               fifo_rdreq, dig, ss, words);
    end
    push(16'h5A3C);
    repeat (2) tick();
    RST = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fifo_rdreq === 1'b1) pulses++;
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL rst_latch_after cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
    nvec++; if (pulses != 1) begin nfail++; $display("FAIL rst_latch_pulses got=%0d want=1", pulses); end
    nvec++; if (words !== 8'd1) begin nfail++; $display("FAIL rst_latch_words got=%0d want=1", words); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0 && fq.size() < 3) push(16'($urandom));
      EN = ($urandom_range(0, 9) != 0);
      tick();
      nvec++;
      if ({fifo_rdreq, dig, ss, words} !== {m_rdreq, m_dig, m_ss, m_words}) begin
        nfail++;
        $display("FAIL random cyc=%0d got rd=%b dig=%h ss=%h words=%0d want rd=%b dig=%h ss=%h words=%0d",
                 cyc, fifo_rdreq, dig, ss, words, m_rdreq, m_dig, m_ss, m_words);
      end
    end
    EN = 1'b1;
  endtask

  initial begin
    RST        = 1'b0;
    EN         = 1'b1;
    fifo_empty = 1'b1;
    fifo_q     = 16'h0000;
    pend_word  = 16'h0000;
    rd_pend    = 1'b0;
    model_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_freeze();
    test_midframe_fill();
    test_reset_latch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
